// File: rtl/spi_sram_responder.sv
// SQI serial SRAM responder (23LC1024-style): SPI-to-quad entry, quad read/write
// with sequential pointer, and quad-to-SPI exit. SCK is oversampled on clk.
module spi_sram_responder #(
    parameter int MEM_ADDR_WIDTH = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic sram_cs_n,
    input  logic sram_sck,
    input  logic sram_sio0_i,
    input  logic sram_sio1_i,
    input  logic sram_sio2_i,
    input  logic sram_sio3_i,
    output logic sram_sio0_o,
    output logic sram_sio1_o,
    output logic sram_sio2_o,
    output logic sram_sio3_o,
    output logic sram_sio_oe,
    output logic quad_mode,
    output logic selected
);
    localparam int AW = MEM_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;
    state_t state, state_next;

    logic          sck_q, rise, fall, sample, last_cmd, mem_we;
    logic [3:0]    nib_in, sio_q, hi_nib;
    logic [6:0]    cmd_sr;
    logic [7:0]    cmd_byte, quad_byte, rd_byte;
    logic [AW-5:0] addr_sr;
    logic [AW-1:0] addr_next, ptr;
    logic [2:0]    cnt;
    logic          half, is_write, pend_quad, pend_spi;
    logic [7:0]    mem [0:(1<<AW)-1];

    assign nib_in    = {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i};
    assign rise      = sram_sck & ~sck_q;
    assign fall      = ~sram_sck & sck_q;
    assign sample    = rise & ~sram_cs_n;
    assign cmd_byte  = {cmd_sr, sram_sio0_i};
    assign quad_byte = {hi_nib, nib_in};
    // Only the low address bits are kept; upper address nibbles shift out.
    assign addr_next = {addr_sr, nib_in};
    assign last_cmd  = quad_mode ? (cnt == 3'd1) : (cnt == 3'd7);
    assign rd_byte   = mem[ptr];
    assign mem_we    = !reset && sample && (state == WRITE) && half;

    assign {sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o} = sio_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (sram_cs_n) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  state_next = CMD;
                CMD: if (sample && last_cmd) begin
                    if (quad_mode && (quad_byte == 8'h03 || quad_byte == 8'h02))
                        state_next = ADDR;
                    else
                        state_next = IGNORE;
                end
                ADDR:  if (sample && cnt == 3'd5) state_next = is_write ? WRITE : DUMMY;
                DUMMY: if (sample && cnt == 3'd1) state_next = READ;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= quad_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q       <= 1'b0;
            selected    <= 1'b0;
            quad_mode   <= 1'b0;
            pend_quad   <= 1'b0;
            pend_spi    <= 1'b0;
            sram_sio_oe <= 1'b0;
            sio_q       <= '0;
            cnt         <= '0;
            half        <= 1'b0;
            is_write    <= 1'b0;
            cmd_sr      <= '0;
            hi_nib      <= '0;
            addr_sr     <= '0;
            ptr         <= '0;
        end else begin
            sck_q    <= sram_sck;
            selected <= ~sram_cs_n;
            if (sram_cs_n) begin
                // Deselect: mode switch lands here, any partial byte is dropped.
                sram_sio_oe <= 1'b0;
                sio_q       <= '0;
                cnt         <= '0;
                half        <= 1'b0;
                if (pend_quad) quad_mode <= 1'b1;
                if (pend_spi)  quad_mode <= 1'b0;
                pend_quad   <= 1'b0;
                pend_spi    <= 1'b0;
            end else begin
                if (state == IDLE) begin
                    cnt  <= '0;
                    half <= 1'b0;
                end
                if (sample) begin
                    case (state)
                        CMD: begin
                            cmd_sr <= cmd_byte[6:0];
                            hi_nib <= nib_in;
                            cnt    <= cnt + 3'd1;
                            if (last_cmd) begin
                                cnt      <= '0;
                                is_write <= (quad_byte == 8'h02);
                                if (!quad_mode && cmd_byte == 8'h38) pend_quad <= 1'b1;
                                if (quad_mode && quad_byte == 8'hFF) pend_spi <= 1'b1;
                            end
                        end
                        ADDR: begin
                            addr_sr <= addr_next[AW-5:0];
                            cnt     <= cnt + 3'd1;
                            if (cnt == 3'd5) begin
                                cnt  <= '0;
                                ptr  <= addr_next;
                                half <= 1'b0;
                            end
                        end
                        DUMMY: cnt <= cnt + 3'd1;
                        WRITE: begin
                            if (!half) begin
                                hi_nib <= nib_in;
                                half   <= 1'b1;
                            end else begin
                                ptr  <= ptr + AW'(1);
                                half <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                if (fall && state == READ) begin
                    sram_sio_oe <= 1'b1;
                    sio_q       <= half ? rd_byte[3:0] : rd_byte[7:4];
                    if (half) ptr <= ptr + AW'(1);
                    half <= ~half;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: scripted and randomized quad transactions checked
// against a byte-array memory model plus a per-cycle output/mode monitor.
module tb_spi_sram_responder;
    localparam int AW   = 17;
    localparam int MASK = (1 << AW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sram_cs_n = 1'b1;
    logic sram_sck = 1'b0;
    logic sram_sio0_i = 1'b0, sram_sio1_i = 1'b0, sram_sio2_i = 1'b0, sram_sio3_i = 1'b0;
    logic sram_sio0_o, sram_sio1_o, sram_sio2_o, sram_sio3_o;
    logic sram_sio_oe, quad_mode, selected;

    always #5 clk = ~clk;

    spi_sram_responder #(.MEM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .sram_cs_n(sram_cs_n), .sram_sck(sram_sck),
        .sram_sio0_i(sram_sio0_i), .sram_sio1_i(sram_sio1_i),
        .sram_sio2_i(sram_sio2_i), .sram_sio3_i(sram_sio3_i),
        .sram_sio0_o(sram_sio0_o), .sram_sio1_o(sram_sio1_o),
        .sram_sio2_o(sram_sio2_o), .sram_sio3_o(sram_sio3_o),
        .sram_sio_oe(sram_sio_oe), .quad_mode(quad_mode), .selected(selected)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0, oe_ok = 0, quad_ok = 0;
    bit model_quad = 0;
    int pend_m = -1;
    logic [7:0] mem_m [int];
    logic [7:0] wbuf [0:7];
    logic [7:0] rd_buf [0:7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sio_out();
        return {sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o};
    endfunction

    // Per-cycle monitor: selected mirrors cs_n, no drive outside read data, mode matches model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("selected", int'(selected), int'(!sram_cs_n));
            if (!oe_ok) chk("no_drive", int'({sram_sio_oe, sio_out()}), 0);
            if (quad_ok) chk("quad_mode", int'(quad_mode), int'(model_quad));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        sram_sck = 1'b1; tick(2);
        sram_sck = 1'b0; tick(2);
    endtask

    task automatic clk_nib(input logic [3:0] n);
        {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i} = n;
        tick(2);
        pulse();
    endtask

    task automatic sel();
        sram_cs_n = 1'b0;
        tick(2);
    endtask

    task automatic desel();
        quad_ok = 0;
        sram_cs_n = 1'b1;
        sram_sck = 1'b0;
        tick(3);
        oe_ok = 0;
        if (pend_m >= 0) model_quad = (pend_m == 1);
        pend_m = -1;
        quad_ok = 1;
        tick(1);
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) clk_nib({3'($urandom), b[i]});
    endtask

    task automatic quad_cmd(input logic [7:0] b);
        clk_nib(b[7:4]);
        clk_nib(b[3:0]);
    endtask

    task automatic quad_addr(input int a);
        for (int i = 5; i >= 0; i--) clk_nib(4'(a >> (4 * i)));
    endtask

    task automatic enter_quad();
        sel(); spi_cmd(8'h38);
        pend_m = 1;
        desel();
    endtask

    task automatic quad_write(input int a, input int n, input bit partial);
        sel(); quad_cmd(8'h02); quad_addr(a);
        for (int i = 0; i < n; i++) begin
            clk_nib(wbuf[i][7:4]);
            clk_nib(wbuf[i][3:0]);
            mem_m[(a + i) & MASK] = wbuf[i];
        end
        if (partial) clk_nib(4'($urandom));
        desel();
    endtask

    task automatic quad_read(input int a, input int n);
        logic [3:0] h, l;
        sel(); quad_cmd(8'h03); quad_addr(a);
        clk_nib(4'h0);
        {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i} = 4'h0;
        tick(2);
        sram_sck = 1'b1; tick(2);
        oe_ok = 1;
        sram_sck = 1'b0; tick(2);
        for (int i = 0; i < n; i++) begin
            chk("rd_oe_hi", int'(sram_sio_oe), 1);
            h = sio_out();
            pulse();
            chk("rd_oe_lo", int'(sram_sio_oe), 1);
            l = sio_out();
            pulse();
            rd_buf[i] = {h, l};
        end
        desel();
    endtask

    task automatic check_model(input string name, input int a, input int n);
        quad_read(a, n);
        for (int i = 0; i < n; i++) chk(name, int'(rd_buf[i]), int'(mem_m[(a + i) & MASK]));
    endtask

    initial begin
        int a, n;
        logic [7:0] b;

        tick(3);
        chk("rst_oe", int'(sram_sio_oe), 0);
        chk("rst_quad", int'(quad_mode), 0);
        chk("rst_selected", int'(selected), 0);
        chk("rst_sio", int'(sio_out()), 0);
        reset = 1'b0;
        tick(1);
        chk_en = 1; quad_ok = 1;

        // SPI 0x38 -> quad mode after deselect
        enter_quad();
        chk("enter_quad", int'(quad_mode), 1);

        // write/read at 0x015DA0
        wbuf[0] = 8'h12; wbuf[1] = 8'h34;
        quad_write(32'h015DA0, 2, 0);
        quad_read(32'h015DA0, 2);
        chk("rd_nib1", int'(rd_buf[0][7:4]), 1);
        chk("rd_nib2", int'(rd_buf[0][3:0]), 2);
        chk("rd_nib3", int'(rd_buf[1][7:4]), 3);
        chk("rd_nib4", int'(rd_buf[1][3:0]), 4);

        // pointer wrap
        wbuf[0] = 8'hAB; wbuf[1] = 8'hCD;
        quad_write(32'h01FFFF, 2, 0);
        quad_read(32'h01FFFF, 2);
        chk("wrap_top", int'(rd_buf[0]), 8'hAB);
        chk("wrap_zero", int'(rd_buf[1]), 8'hCD);
        quad_read(32'h000000, 1);
        chk("wrap_zero_direct", int'(rd_buf[0]), 8'hCD);

        // aborted partial byte leaves memory untouched
        wbuf[0] = 8'h77;
        quad_write(32'h000010, 1, 0);
        quad_write(32'h000010, 0, 1);
        quad_read(32'h000010, 1);
        chk("abort_keep", int'(rd_buf[0]), 8'h77);

        // quad 0xFF -> back to SPI; SPI non-0x38 ignored
        sel(); quad_cmd(8'hFF); pend_m = 0; desel();
        chk("exit_quad", int'(quad_mode), 0);
        sel(); spi_cmd(8'h03); repeat (8) clk_nib(4'($urandom)); desel();
        chk("spi_ignore_mode", int'(quad_mode), 0);
        enter_quad();

        // unknown quad cmd ignored
        sel(); quad_cmd(8'h55); repeat (12) clk_nib(4'($urandom)); desel();
        check_model("after_ignore", 32'h015DA0, 2);

        // randomized traffic
        for (int it = 0; it < 24; it++) begin
            a = int'($urandom & 32'hFFFFFF);
            if (it % 6 == 0) a = (a & 32'hFF0000) | 32'h01FFFE;
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            quad_write(a, n, 1'($urandom));
            if (it % 3 == 0) begin
                b = 8'($urandom);
                while (b == 8'h02 || b == 8'h03 || b == 8'hFF) b = 8'($urandom);
                sel(); quad_cmd(b);
                repeat ($urandom_range(2, 14)) clk_nib(4'($urandom));
                desel();
            end
            check_model("rand_rd", a, n);
        end

        // reset in the middle of a write
        wbuf[0] = 8'h5A; wbuf[1] = 8'h66;
        quad_write(32'h000100, 2, 0);
        sel(); quad_cmd(8'h02); quad_addr(32'h000100);
        clk_nib(4'h3); clk_nib(4'hC); clk_nib(4'h9);
        chk_en = 0; quad_ok = 0; oe_ok = 0;
        reset = 1'b1; sram_cs_n = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        model_quad = 0; pend_m = -1;
        chk("reset_quad", int'(quad_mode), 0);
        chk_en = 1; quad_ok = 1;
        enter_quad();
        quad_read(32'h000100, 2);
        chk("reset_done_byte", int'(rd_buf[0]), 8'h3C);
        chk("reset_partial", int'(rd_buf[1]), 8'h66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_sram_responder.md
SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 17, giving log2 of byte capacity (128 KiB, 23LC1024-equivalent).
REQ-002 SHALL have port clk, input, 1, the single clock; sram_sck is sampled in this domain.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sram_cs_n, input, 1, chip select, active low.
REQ-005 SHALL have port sram_sck, input, 1, serial clock, sampled on clk.
REQ-006 SHALL have ports sram_sio0_i..sram_sio3_i, input, 1 each, bus levels, nibble = {sio3,sio2,sio1,sio0}.
REQ-007 SHALL have ports sram_sio0_o..sram_sio3_o, output, 1 each, responder drive data.
REQ-008 SHALL have port sram_sio_oe, output, 1, responder drives SIO when 1.
REQ-009 SHALL have port quad_mode, output, 1, 1 = SQI mode active.
REQ-010 SHALL have port selected, output, 1, registered copy of !sram_cs_n.

Function
REQ-011 SHALL register sram_sck each clk as sck_q; rise = sram_sck & !sck_q; fall = !sram_sck & sck_q.
REQ-012 SHALL sample SIO inputs only on rise cycles with sram_cs_n=0; SHALL update sram_sio*_o and sram_sio_oe only on fall cycles, registered, valid next clk.
REQ-013 SHALL use states IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE; sram_cs_n=1 in any state forces IDLE next clk, sram_sio_oe=0, outputs 0.
REQ-014 IDLE -> CMD on first clk with sram_cs_n=0; bit/nibble counters cleared.
REQ-015 SPI mode (quad_mode=0): CMD shifts sram_sio0_i MSB-first, 8 rises; value 0x38 sets a pending-quad flag, any other value -> IGNORE.
REQ-016 Quad mode: CMD takes 2 nibbles, high first; 0x03 -> ADDR(read), 0x02 -> ADDR(write), 0xFF sets pending-SPI flag, else -> IGNORE.
REQ-017 Pending mode flags SHALL take effect on the clk sram_cs_n is sampled 1; flags cleared on apply or reset.
REQ-018 ADDR SHALL take 6 nibbles (24 bits, MSB first); byte pointer = low MEM_ADDR_WIDTH bits, upper bits ignored.
REQ-019 Read: after ADDR, DUMMY SHALL consume 2 rises with sram_sio_oe=0; on fall after second dummy rise, sram_sio_oe=1 and output mem[ptr][7:4]; following fall mem[ptr][3:0]; then ptr+1, repeat (sequential mode) until deselect.
REQ-020 Write: WRITE SHALL assemble nibbles high-first; on second nibble's rise write byte to mem[ptr] and ptr+1; partial byte at deselect discarded.
REQ-021 Pointer SHALL wrap from 2^MEM_ADDR_WIDTH-1 to 0.
REQ-022 IGNORE SHALL hold sram_sio_oe=0 and ignore all rises until deselect.
REQ-023 sram_sio_oe SHALL be 0 in every state except READ data phase.
REQ-024 Rise and fall cannot coincide; cs_n deselect same clk as rise SHALL discard that sample.
REQ-025 Memory SHALL be an internal byte array, single write port, no reset of contents.

Reset
REQ-026 On reset: state IDLE, quad_mode=0, pending flags 0, sram_sio_oe=0, sram_sio*_o=0, selected=0, sck_q=0, counters 0.
REQ-027 Reset mid-transaction SHALL abort it with no memory write of an incomplete byte; completed bytes remain.

Verification
REQ-028 Reset, cs_n=0, sio0 bits 0,0,1,1,1,0,0,0 on 8 rises, cs_n=1 -> quad_mode=1 next clk, sram_sio_oe never 1.
REQ-029 Quad write: cmd 0x02, addr 0x015DA0, nibbles 1,2,3,4, cs_n=1 -> mem[0x15DA0]=0x12, mem[0x15DA1]=0x34.
REQ-030 Quad read: cmd 0x03, addr 0x015DA0, 6 more rises -> 2 dummy with oe=0, then nibbles 1,2,3,4 with oe=1; oe=0 clk after cs_n=1.
REQ-031 Wrap: write addr 0x01FFFF bytes 0xAB,0xCD -> mem[0x1FFFF]=0xAB, mem[0x00000]=0xCD.
REQ-032 Abort: write to 0x000010 with one data nibble then cs_n=1 -> mem[0x10] unchanged; next cmd 0x03 decoded correctly.
REQ-033 Quad cmd 0xFF then deselect -> quad_mode=0; quad cmd 0x55 -> IGNORE, oe stays 0, no memory change.
